p2s_frame_serializer: RTL and testbench
=======================================

Name: p2s_frame_serializer

Overview:
Parametrised parallel-to-serial frame transmitter, successor to the single-word wrapper serializer. Accepts words over a valid/ready handshake into a one-deep holding buffer. Shifts each word out as a frame of programmable length with per-word bit-order select. Supports back-to-back frames with no idle gap and tri-states the serial line when idle. Sits between the packet/control logic and the physical serial pin.

Parameters:
WIDTH, 8, parallel word width in bits (>=2)
CW, $clog2(WIDTH+1), localparam, width of frame length and bit counter

Ports:
Clock  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset, sampled on rising edge of Clock
Enable  input  1  shift enable; when 0, shift register, bit counter and frame progress hold
in_data  input  WIDTH  parallel word to send
in_len  input  CW  frame length in bits, 1..WIDTH; 0 or >WIDTH means WIDTH
in_msb_first  input  1  1: send bit (len-1) first down to bit 0; 0: bit 0 first up to bit (len-1)
in_valid  input  1  word/len/mode valid
in_ready  output  1  block can accept a word this cycle
serial  output  1  serial data; 1'bz when serial_oe=0
serial_oe  output  1  high while a frame bit is being driven
busy  output  1  frame in progress or holding buffer occupied
complete  output  1  one-cycle pulse after the last bit of each frame retires

Behaviour:
- Reset (Reset=0 at edge): state IDLE, buffer empty, counter 0, serial_oe=0, serial=z, busy=0, complete=0. in_ready forced 0 while Reset=0 and is 1 on the first cycle after release. Reset mid-frame aborts the frame and drops the buffered word. No complete pulse is issued for an aborted frame.
- Handshake: a word is accepted on an edge with in_valid=1 and in_ready=1. in_ready=1 when the holding buffer is empty, independent of Enable. in_data, in_len and in_msb_first are captured together. A length of 0 or >WIDTH is normalised to WIDTH at capture.
- States:
  - IDLE: buffer empty, serial_oe=0. A word accepted in IDLE loads directly into the shift register and the state goes to SHIFT; the buffer stays empty.
  - SHIFT: serial_oe=1. serial = current frame bit, driven combinationally from the shift register, bit-order per the captured mode. Each edge with Enable=1 advances one bit and increments the counter. A frame of N bits occupies exactly N Enable=1 cycles.
- Last bit (counter==N-1, Enable=1 at edge):
  - If the buffer is full, the shift register loads from the buffer on that same edge, the buffer empties, and the state stays SHIFT. The next frame's first bit is driven in the following cycle, with no gap.
  - If the buffer is empty and in_valid=1, the word is accepted directly into the shift register and the state stays SHIFT, also with no gap.
  - Otherwise the state goes to IDLE and serial_oe falls in the following cycle.
- complete: registered; high for exactly one cycle after each last-bit edge.
- Enable=0 in SHIFT: serial_oe stays 1, serial holds the current bit, the counter holds, and acceptance into the buffer still works.
- In SHIFT with the buffer empty, in_ready=1 and an accepted word goes into the buffer (unless on the last-bit edge, as above). With the buffer full, in_ready=0.
- busy = (state==SHIFT) | buffer full.
- Bits above in_len-1 of in_data are never driven.

Test Plan:
- Reset then in_data=8'hA5, in_len=8, msb_first=1, Enable=1 -> serial 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; complete pulses on cycle 9; serial_oe=0 and serial=z from cycle 9.
- in_data=8'hA5, in_len=4, msb_first=0 -> serial 1,0,1,0 (bits 0..3) then z; complete after exactly 4 bit cycles.
- Two words 8'hFF then 8'h00 offered back-to-back (len 8) -> second word buffered; in_ready=0 until the first last-bit edge; 16 contiguous bits with no idle cycle; complete pulses twice, 8 cycles apart.
- Enable toggled 0 for 3 cycles mid-frame on 8'h81 MSB-first -> bit held, serial_oe=1 throughout; frame finishes 3 cycles later; bit sequence unchanged.
- Reset=0 asserted at bit 4 of a frame with a word buffered -> next cycle serial=z, busy=0, no complete pulse; a new word sends correctly after release.
- in_len=0 and in_len=15 with WIDTH=8 -> both send 8 bits.

Source files
------------

// File: rtl/p2s_frame_serializer.sv
// Parallel-to-serial frame transmitter: valid/ready intake into a one-deep
// holding buffer, programmable frame length, per-word bit order, tri-stated line.
module p2s_frame_serializer #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_len,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial,
  output logic             serial_oe,
  output logic             busy,
  output logic             complete
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shiftReg_q;
  logic [CW-1:0]    len_q;
  logic             msb_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] bufData_q;
  logic [CW-1:0]    bufLen_q;
  logic             bufMsb_q;
  logic             bufFull_q;
  logic             complete_q;

  logic [CW-1:0]    capLen_d;
  logic [WIDTH-1:0] capWord_d;
  logic             accept;
  logic             lastBit;

  // MSB-first words are pre-aligned so bit (len-1) sits at the top; the line
  // then always taps a fixed end of the register and upper bits fall off.
  always_comb begin
    capLen_d = in_len;
    if (in_len == '0 || in_len > CW'(WIDTH))
      capLen_d = CW'(WIDTH);
    capWord_d = in_msb_first ? (in_data << (CW'(WIDTH) - capLen_d)) : in_data;
  end

  assign in_ready = Reset & ~bufFull_q;
  assign accept   = in_valid & in_ready;
  assign lastBit  = (state_q == SHIFT) && Enable && (cnt_q == len_q - CW'(1));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      len_q      <= CW'(WIDTH);
      msb_q      <= 1'b0;
      cnt_q      <= '0;
      bufData_q  <= '0;
      bufLen_q   <= CW'(WIDTH);
      bufMsb_q   <= 1'b0;
      bufFull_q  <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shiftReg_q <= capWord_d;
            len_q      <= capLen_d;
            msb_q      <= in_msb_first;
            cnt_q      <= '0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (lastBit) begin
            // Chain the next frame on the retiring edge so no idle bit appears.
            complete_q <= 1'b1;
            cnt_q      <= '0;
            if (bufFull_q) begin
              shiftReg_q <= bufData_q;
              len_q      <= bufLen_q;
              msb_q      <= bufMsb_q;
              bufFull_q  <= 1'b0;
            end else if (accept) begin
              shiftReg_q <= capWord_d;
              len_q      <= capLen_d;
              msb_q      <= in_msb_first;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            if (Enable) begin
              shiftReg_q <= msb_q ? (shiftReg_q << 1) : (shiftReg_q >> 1);
              cnt_q      <= cnt_q + CW'(1);
            end
            if (accept) begin
              bufData_q <= capWord_d;
              bufLen_q  <= capLen_d;
              bufMsb_q  <= in_msb_first;
              bufFull_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_oe = (state_q == SHIFT);
  assign serial    = serial_oe ? (msb_q ? shiftReg_q[WIDTH-1] : shiftReg_q[0]) : 1'bz;
  assign busy      = (state_q == SHIFT) | bufFull_q;
  assign complete  = complete_q;

endmodule

// File: tb/tb_p2s_frame_serializer.sv
// Self-checking bench for p2s_frame_serializer: expected serial bits are
// queued when a word is offered and popped as the line drives them.
module tb_p2s_frame_serializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Enable;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    in_len;
  logic             in_msb_first;
  logic             in_valid;
  logic             in_ready;
  logic             serial;
  logic             serial_oe;
  logic             busy;
  logic             complete;

  int   nAsserts = 0;
  int   nFails   = 0;
  logic expQ[$];
  logic prevOe   = 1'b0;
  logic lastBit  = 1'b0;
  int   pulses   = 0;
  int   cycles;
  logic held;

  p2s_frame_serializer #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .in_data(in_data),
    .in_len(in_len), .in_msb_first(in_msb_first), .in_valid(in_valid),
    .in_ready(in_ready), .serial(serial), .serial_oe(serial_oe),
    .busy(busy), .complete(complete)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame model: walks bit indices directly from the word.
  task automatic pushFrame(input logic [WIDTH-1:0] d, input logic [CW-1:0] len, input logic msb);
    int n;
    n = (len == 0 || len > WIDTH) ? WIDTH : int'(len);
    for (int i = 0; i < n; i++)
      expQ.push_back(msb ? d[n-1-i] : d[i]);
  endtask

  // One clock: sample #1 after the edge, pop a new bit only after an
  // enabled edge, otherwise the line must hold its previous bit.
  task automatic tick();
    logic enAtEdge;
    enAtEdge = Enable;
    @(posedge Clock);
    #1;
    if (serial_oe === 1'b1) begin
      if (enAtEdge || !prevOe) begin
        nAsserts++;
        assert (expQ.size() != 0) else begin
          nFails++;
          $error("[TB] FAIL bit_queue observed=empty expected=pending_bit");
        end
        if (expQ.size() != 0) begin
          lastBit = expQ.pop_front();
          check("serial_bit", serial, lastBit);
        end
      end else begin
        check("hold_bit", serial, lastBit);
      end
    end else begin
      check("serial_z", serial, 1'bz);
    end
    prevOe = (serial_oe === 1'b1);
    if (complete === 1'b1) pulses++;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [CW-1:0] len, input logic msb);
    in_data      = d;
    in_len       = len;
    in_msb_first = msb;
    in_valid     = 1'b1;
    check("ready_at_offer", in_ready, 1'b1);
    pushFrame(d, len, msb);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitComplete(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (complete === 1'b1) return;
    end
    check("complete_timeout", 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input int nGot, input int nExp);
    check({tag, "_cycles"}, nGot, nExp);
    check({tag, "_queue_empty"}, expQ.size(), 0);
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b1; in_valid = 1'b0;
    in_data = '0; in_len = '0; in_msb_first = 1'b0;
    tick(); tick();
    check("rst_ready", in_ready, 1'b0);
    check("rst_oe", serial_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_complete", complete, 1'b0);
    Reset = 1'b1;
    #1;
    check("ready_after_release", in_ready, 1'b1);

    // A5 MSB-first, full length
    applyStimulus(8'hA5, 4'd8, 1'b1);
    waitComplete(cycles);
    checkOutput("a5_msb", cycles, 8);
    check("a5_oe_low", serial_oe, 1'b0);
    check("a5_busy_low", busy, 1'b0);
    tick();
    check("a5_complete_one_cycle", complete, 1'b0);

    // A5 LSB-first, 4 bits
    applyStimulus(8'hA5, 4'd4, 1'b0);
    waitComplete(cycles);
    checkOutput("a5_lsb4", cycles, 4);
    tick();

    // Back-to-back FF then 00
    pulses = 0;
    applyStimulus(8'hFF, 4'd8, 1'b1);
    applyStimulus(8'h00, 4'd8, 1'b1);
    check("b2b_ready_full", in_ready, 1'b0);
    check("b2b_busy", busy, 1'b1);
    waitComplete(cycles);
    check("b2b_first_cycles", cycles, 7);
    check("b2b_ready_after_last", in_ready, 1'b1);
    check("b2b_no_gap", serial_oe, 1'b1);
    waitComplete(cycles);
    checkOutput("b2b_second", cycles, 8);
    check("b2b_pulses", pulses, 2);
    tick();

    // Enable stall mid-frame
    applyStimulus(8'h81, 4'd8, 1'b1);
    tick(); tick(); tick();
    Enable = 1'b0;
    held = serial;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_oe", serial_oe, 1'b1);
      check("stall_bit", serial, held);
    end
    Enable = 1'b1;
    waitComplete(cycles);
    checkOutput("stall", cycles, 5);
    tick();

    // Reset at bit 4 with a word buffered
    pulses = 0;
    applyStimulus(8'hA5, 4'd8, 1'b1);
    applyStimulus(8'h3C, 4'd8, 1'b0);
    tick(); tick(); tick();
    Reset = 1'b0;
    expQ.delete();
    tick();
    check("abort_oe", serial_oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_complete", complete, 1'b0);
    Reset = 1'b1;
    tick();
    check("abort_no_pulse", pulses, 0);
    applyStimulus(8'h5A, 4'd6, 1'b1);
    waitComplete(cycles);
    checkOutput("post_abort", cycles, 6);
    tick();

    // Out-of-range lengths normalise to WIDTH
    applyStimulus(8'hC3, 4'd0, 1'b1);
    waitComplete(cycles);
    checkOutput("len0", cycles, 8);
    tick();
    applyStimulus(8'h96, 4'd15, 1'b0);
    waitComplete(cycles);
    checkOutput("len15", cycles, 8);
    tick();
    check("final_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
